// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_REQ requesters.
// Define ARB_PRIO0_EN to give requester 0 fixed priority over the rest.
module bram_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int LOG_NUM_REQ     = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_MAX_ADDRESS = 16,
  parameter int BRAM_LATENCY    = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               configure,
  input  logic [NUM_REQ-1:0]                 req_mask,
  input  logic [NUM_REQ-1:0]                 req_in,
  input  logic [NUM_REQ*LOG_MAX_ADDRESS-1:0] address_in,
  output logic [NUM_REQ-1:0]                 grant_out,
  output logic                               bram_en,
  output logic [LOG_MAX_ADDRESS-1:0]         bram_address,
  input  logic [DATA_WIDTH-1:0]              bram_data_in,
  output logic [NUM_REQ-1:0]                 valid_out,
  output logic [DATA_WIDTH-1:0]              data_out
);

  localparam int L = BRAM_LATENCY;

  logic [NUM_REQ-1:0]     mask_r;
  logic [NUM_REQ-1:0]     elig;
  logic [NUM_REQ-1:0]     rr_elig;
  logic [LOG_NUM_REQ-1:0] rr_ptr;
  logic [LOG_NUM_REQ-1:0] win;
  logic [LOG_NUM_REQ-1:0] idx;
  logic                   found;
  logic                   upd_ptr;
  logic [LOG_NUM_REQ-1:0] issue_k;

  // Tag pipe: stage L-1 lines up with the cycle the BRAM word arrives.
  logic [L-1:0]                  pipe_v;
  logic [L-1:0][LOG_NUM_REQ-1:0] pipe_k;

  always_comb begin
    elig      = req_in & mask_r;
    rr_elig   = elig;
    grant_out = '0;
    win       = '0;
    idx       = '0;
    found     = 1'b0;
    upd_ptr   = 1'b0;
`ifdef ARB_PRIO0_EN
    rr_elig[0] = 1'b0;
`endif
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = LOG_NUM_REQ'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && rr_elig[idx]) begin
        found   = 1'b1;
        win     = idx;
        upd_ptr = 1'b1;
      end
    end
`ifdef ARB_PRIO0_EN
    if (elig[0]) begin
      found   = 1'b1;
      win     = '0;
      upd_ptr = 1'b0;
    end
`endif
    if (found) grant_out[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r       <= '0;
      rr_ptr       <= LOG_NUM_REQ'(NUM_REQ - 1);
      bram_en      <= 1'b0;
      bram_address <= '0;
      issue_k      <= '0;
      pipe_v       <= '0;
      pipe_k       <= '0;
      valid_out    <= '0;
      data_out     <= '0;
    end else begin
      if (configure) mask_r <= req_mask;
      if (upd_ptr) rr_ptr <= win;
      bram_en <= found;
      if (found) begin
        bram_address <= address_in[int'(win)*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
        issue_k      <= win;
      end
      pipe_v[0] <= bram_en;
      pipe_k[0] <= issue_k;
      for (int i = 1; i < L; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_k[i] <= pipe_k[i-1];
      end
      valid_out <= pipe_v[L-1] ? (NUM_REQ'(1) << pipe_k[L-1]) : '0;
      if (pipe_v[L-1]) data_out <= bram_data_in;
    end
  end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Randomized bench for bram_read_arbiter against a cycle-indexed
// expectation model; BRAM returns addr[7:0] one cycle after bram_en.
module tb_bram_read_arbiter;
  localparam int N    = 4;
  localparam int LN   = 2;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int LAT  = 1;
  localparam int MAXC = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            configure = 1'b0;
  logic [N-1:0]    req_mask = '0;
  logic [N-1:0]    req_in = '0;
  logic [N*AW-1:0] address_in = '0;
  logic [N-1:0]    grant_out;
  logic            bram_en;
  logic [AW-1:0]   bram_address;
  logic [DW-1:0]   bram_data_in = '0;
  logic [N-1:0]    valid_out;
  logic [DW-1:0]   data_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [N-1:0]  m_mask;
  int            m_ptr;
  logic          exp_en   [MAXC];
  logic [AW-1:0] exp_addr [MAXC];
  logic [N-1:0]  exp_val  [MAXC];
  logic [DW-1:0] exp_data [MAXC];

  always #5 clk = ~clk;

  always @(posedge clk)
    bram_data_in <= bram_en ? bram_address[7:0] : DW'($urandom);

  bram_read_arbiter #(
    .NUM_REQ(N), .LOG_NUM_REQ(LN), .DATA_WIDTH(DW),
    .LOG_MAX_ADDRESS(AW), .BRAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure),
    .req_mask(req_mask), .req_in(req_in),
    .address_in(address_in), .grant_out(grant_out),
    .bram_en(bram_en), .bram_address(bram_address),
    .bram_data_in(bram_data_in), .valid_out(valid_out),
    .data_out(data_out)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] e, int ptr);
`ifdef ARB_PRIO0_EN
    if (e[0]) return 0;
    e[0] = 1'b0;
`endif
    for (int s = 1; s <= N; s++)
      if (e[(ptr + s) % N]) return (ptr + s) % N;
    return -1;
  endfunction

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_en[i]   = 1'b0;
      exp_addr[i] = '0;
      exp_val[i]  = '0;
      exp_data[i] = '0;
    end
  endtask

  task automatic check_regs();
    check("bram_en", 64'(bram_en), 64'(exp_en[cyc]));
    if (exp_en[cyc])
      check("bram_addr", 64'(bram_address), 64'(exp_addr[cyc]));
    check("valid_out", 64'(valid_out), 64'(exp_val[cyc]));
    if (exp_val[cyc] != '0)
      check("data_out", 64'(data_out), 64'(exp_data[cyc]));
  endtask

  task automatic step(input logic cfg,
                      input logic [N-1:0] msk,
                      input logic [N-1:0] req);
    int w;
    logic [N-1:0] eg;
    logic [AW-1:0] a;
    @(negedge clk);
    check_regs();
    configure = cfg;
    req_mask  = msk;
    req_in    = req;
    for (int k = 0; k < N; k++)
      address_in[k*AW +: AW] = AW'($urandom);
    #1;
    w  = pick(req & m_mask, m_ptr);
    eg = (w < 0) ? '0 : N'(1 << w);
    check("grant_out", 64'(grant_out), 64'(eg));
    if (w >= 0) begin
      a = address_in[w*AW +: AW];
      exp_en[cyc+1]       = 1'b1;
      exp_addr[cyc+1]     = a;
      exp_val[cyc+2+LAT]  = eg;
      exp_data[cyc+2+LAT] = a[7:0];
`ifdef ARB_PRIO0_EN
      if (w != 0) m_ptr = w;
`else
      m_ptr = w;
`endif
    end
    if (cfg) m_mask = msk;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_in    = '0;
    configure = 1'b0;
    #1;
    check("rst_valid", 64'(valid_out), 64'(0));
    check("rst_en", 64'(bram_en), 64'(0));
    check("rst_grant", 64'(grant_out), 64'(0));
    m_mask = '0;
    m_ptr  = N - 1;
    clear_from(cyc);
    cyc++;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_valid", 64'(valid_out), 64'(0));
      cyc++;
    end
    rst = 1'b1;
  endtask

  initial begin
    m_mask = '0;
    m_ptr  = N - 1;
    clear_from(0);
    #1;
    check("init_valid", 64'(valid_out), 64'(0));
    check("init_data", 64'(data_out), 64'(0));
    check("init_en", 64'(bram_en), 64'(0));
    check("init_addr", 64'(bram_address), 64'(0));
    check("init_grant", 64'(grant_out), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // single request
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 4'b0100);
    repeat (4) step(1'b0, 4'b0000, 4'b0000);

    // all requesting from the reset pointer
    do_reset();
    step(1'b1, 4'b1111, 4'b0000);
    repeat (8) step(1'b0, 4'b0000, 4'b1111);
    repeat (4) step(1'b0, 4'b0000, 4'b0000);

    // partial mask, configure cycle still uses old mask
    step(1'b1, 4'b1010, 4'b1111);
    repeat (6) step(1'b0, 4'b0000, 4'b1111);

    // mask everything while a read is in flight
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 4'b0100);
    step(1'b1, 4'b0000, 4'b1111);
    repeat (4) step(1'b0, 4'b0000, 4'b1111);

    // reset between bram_en and data return
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 4'b0010);
    step(1'b0, 4'b0000, 4'b0000);
    do_reset();
    repeat (4) step(1'b0, 4'b0000, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000);

    // randomized traffic
    repeat (300)
      step(($urandom_range(0, 7) == 0), N'($urandom), N'($urandom));
    repeat (5) step(1'b0, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
